ahb_fifo_reg_slave: RTL and testbench

//  AHB-Lite responder: the completer end of the system AHB bus. Decodes a 16-byte window of

---
 rtl/ahb_fifo_reg_slave_if.sv | 31 +++
 rtl/ahb_fifo_reg_slave.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_fifo_reg_slave.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_fifo_reg_slave_if.sv
// rtl/ahb_fifo_reg_slave_if.sv - AHB-Lite signal bundle between a bus master and the register slave
// Purpose: carries one AHB-Lite request/response path.
// Ports (modports):
//   master - drives HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY_IN;
//            observes HRDATA, HREADY_OUT, HRESP, XFER_ERROR_ACCESS
//   slave  - the reverse directions
interface ahb_fifo_reg_slave_if;
  logic        HSELx;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY_IN;
  logic [31:0] HRDATA;
  logic        HREADY_OUT;
  logic [1:0]  HRESP;
  logic        XFER_ERROR_ACCESS;

  modport master (
    output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY_IN,
    input  HRDATA, HREADY_OUT, HRESP, XFER_ERROR_ACCESS
  );

  modport slave (
    input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY_IN,
    output HRDATA, HREADY_OUT, HRESP, XFER_ERROR_ACCESS
  );
endinterface

// File: rtl/ahb_fifo_reg_slave.sv
// rtl/ahb_fifo_reg_slave.sv - AHB-Lite register slave with CTRL/STATUS/DATA FIFO/SCRATCH window
// Purpose: decodes a 16-byte window of word registers and answers with OKAY,
//   wait-stated read or two-cycle ERROR responses.
// Ports:
//   HCLK    - bus clock, rising edge
//   HRESETN - asynchronous reset, active high (1 = reset)
//   bus     - AHB-Lite slave modport (request in, HRDATA/HREADY_OUT/HRESP/XFER_ERROR_ACCESS out)
module ahb_fifo_reg_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          READ_WAIT  = 1
) (
  input logic                 HCLK,
  input logic                 HRESETN,
  ahb_fifo_reg_slave_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_INIT_I = (READ_WAIT > 0) ? READ_WAIT - 1 : 0;
  localparam logic [1:0] WAIT_INIT = WAIT_INIT_I[1:0];
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DATA    = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_ERROR  = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t        state_q, state_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic [1:0]    rd_off_q, rd_off_d;
  logic          wr_pend_q, wr_pend_d;
  logic [1:0]    wr_off_q, wr_off_d;
  logic          ctrl_en_q, ctrl_en_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic          hready_out_q, hready_out_d;
  logic [1:0]    hresp_q, hresp_d;
  logic          xfer_err_q, xfer_err_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          push, pop, flush, accept, req_err, capture;
  logic [1:0]    req_off, cap_off;
  logic [CW-1:0] count_commit;
  logic [31:0]   fifo_head, status_val, read_val;
  logic          unused_ok;

  assign unused_ok = &{1'b0, bus.HBURST, bus.HPROT, bus.HTRANS[0]};
  assign req_off   = bus.HADDR[3:2];

  always_comb begin
    // Retire the write whose data phase ends at this edge; everything below
    // (error checks, read data) sees the register state after that write.
    ctrl_en_d = ctrl_en_q;
    scratch_d = scratch_q;
    push      = 1'b0;
    flush     = 1'b0;
    if (wr_pend_q) begin
      case (wr_off_q)
        OFF_CTRL: begin
          ctrl_en_d = bus.HWDATA[0];
          flush     = bus.HWDATA[1];
        end
        OFF_DATA:    push      = 1'b1;
        OFF_SCRATCH: scratch_d = bus.HWDATA;
        default: ;
      endcase
    end
    count_commit = flush ? '0 : count_q + CW'(push);

    accept  = hready_out_q & bus.HSELx & bus.HREADY_IN & bus.HTRANS[1];
    req_err = (bus.HSIZE != 3'b010) ||
              (bus.HADDR[1:0] != 2'b00) ||
              (bus.HADDR[31:4] != BASE_ADDR[31:4]) ||
              (bus.HWRITE && req_off == OFF_STATUS) ||
              (bus.HWRITE && req_off == OFF_DATA && (!ctrl_en_d || count_commit == FULL_CNT)) ||
              (!bus.HWRITE && req_off == OFF_DATA && count_commit == '0);

    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    rd_off_d     = rd_off_q;
    wr_pend_d    = 1'b0;
    wr_off_d     = wr_off_q;
    hready_out_d = 1'b1;
    hresp_d      = RESP_OKAY;
    xfer_err_d   = 1'b0;
    capture      = 1'b0;
    cap_off      = req_off;

    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          capture = 1'b1;
          cap_off = rd_off_q;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d   = wait_cnt_q - 2'd1;
          hready_out_d = 1'b0;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        hresp_d = RESP_ERROR;
      end
      default: begin
        // IDLE and ERR2 are both final data cycles, so both take new requests.
        state_d = ST_IDLE;
        if (accept) begin
          if (req_err) begin
            state_d      = ST_ERR1;
            hready_out_d = 1'b0;
            hresp_d      = RESP_ERROR;
            xfer_err_d   = 1'b1;
          end else if (bus.HWRITE) begin
            wr_pend_d = 1'b1;
            wr_off_d  = req_off;
          end else if (READ_WAIT == 0) begin
            capture = 1'b1;
          end else begin
            state_d      = ST_WAIT;
            hready_out_d = 1'b0;
            wait_cnt_d   = WAIT_INIT;
            rd_off_d     = req_off;
          end
        end
      end
    endcase

    // An empty FIFO with a push retiring now has HWDATA as its head.
    fifo_head  = (count_q == '0) ? bus.HWDATA : mem_q[rd_ptr_q];
    status_val = (32'(count_commit) << 8) |
                 {30'b0, count_commit == FULL_CNT, count_commit == '0};
    case (cap_off)
      OFF_CTRL:   read_val = {31'b0, ctrl_en_d};
      OFF_STATUS: read_val = status_val;
      OFF_DATA:   read_val = fifo_head;
      default:    read_val = scratch_d;
    endcase
    hrdata_d = capture ? read_val : 32'h0;
    pop      = capture && (cap_off == OFF_DATA);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_commit - CW'(pop);
    end
  end

  always_ff @(posedge HCLK or posedge HRESETN) begin
    if (HRESETN) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 2'd0;
      rd_off_q     <= 2'd0;
      wr_pend_q    <= 1'b0;
      wr_off_q     <= 2'd0;
      ctrl_en_q    <= 1'b0;
      scratch_q    <= 32'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hrdata_q     <= 32'h0;
      hready_out_q <= 1'b1;
      hresp_q      <= RESP_OKAY;
      xfer_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_off_q     <= rd_off_d;
      wr_pend_q    <= wr_pend_d;
      wr_off_q     <= wr_off_d;
      ctrl_en_q    <= ctrl_en_d;
      scratch_q    <= scratch_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hrdata_q     <= hrdata_d;
      hready_out_q <= hready_out_d;
      hresp_q      <= hresp_d;
      xfer_err_q   <= xfer_err_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.HWDATA;
    end
  end

  assign bus.HRDATA            = hrdata_q;
  assign bus.HREADY_OUT        = hready_out_q;
  assign bus.HRESP             = hresp_q;
  assign bus.XFER_ERROR_ACCESS = xfer_err_q;

endmodule

// File: tb/tb_ahb_fifo_reg_slave.sv
// tb/tb_ahb_fifo_reg_slave.sv - directed self-checking bench for ahb_fifo_reg_slave
module tb_ahb_fifo_reg_slave;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] A_CTRL    = BASE + 32'h0;
  localparam logic [31:0] A_STATUS  = BASE + 32'h4;
  localparam logic [31:0] A_DATA    = BASE + 32'h8;
  localparam logic [31:0] A_SCRATCH = BASE + 32'hC;
  localparam logic [2:0]  W         = 3'b010;

  logic HCLK    = 1'b0;
  logic HRESETN = 1'b1;
  int   tests   = 0;
  int   fails   = 0;

  logic [31:0] r_data;
  logic        r_err;
  int          r_waits;
  int          r_pulses;
  logic        r_pfirst;

  ahb_fifo_reg_slave_if bus();
  assign bus.HREADY_IN = bus.HREADY_OUT;

  ahb_fifo_reg_slave #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .READ_WAIT(1)) dut (
    .HCLK(HCLK),
    .HRESETN(HRESETN),
    .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bus_idle();
    bus.HSELx = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = 32'h0;
    bus.HSIZE = W; bus.HBURST = 3'b000; bus.HPROT = 4'h0;
  endtask

  task automatic release_reset();
    @(posedge HCLK); #2 HRESETN = 1'b0;
    @(posedge HCLK); #1;
  endtask

  // Single transfer, called 1 time unit after a rising edge; returns aligned the same way.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                          output int waits, output int pulses, output logic pfirst);
    int cyc;
    bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HADDR = addr; bus.HSIZE = size;
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = wdata;
    waits = 0; pulses = 0; cyc = 0;
    pfirst = bus.XFER_ERROR_ACCESS;
    while (bus.HREADY_OUT !== 1'b1 && cyc < 10) begin
      if (bus.XFER_ERROR_ACCESS === 1'b1) pulses++;
      waits++; cyc++;
      @(posedge HCLK); #1;
    end
    if (bus.XFER_ERROR_ACCESS === 1'b1) pulses++;
    rdata = bus.HRDATA;
    err   = (bus.HRESP === 2'b01);
    if (cyc >= 10) begin
      tests++; fails++;
      $display("FAIL xfer_timeout: addr %h HREADY_OUT stuck at %b", addr, bus.HREADY_OUT);
    end
    @(posedge HCLK); #1;
    bus.HWDATA = 32'h0;
  endtask

  task automatic push_b2b(input int n, input logic [31:0] first);
    int okays = 0;
    for (int i = 0; i < n; i++) begin
      bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = A_DATA; bus.HSIZE = W;
      if (i > 0) bus.HWDATA = first + 32'(i) - 32'd1;
      @(posedge HCLK); #1;
      if (bus.HREADY_OUT === 1'b1 && bus.HRESP === 2'b00) okays++;
    end
    bus_idle();
    bus.HWDATA = first + 32'(n) - 32'd1;
    @(posedge HCLK); #1;
    bus.HWDATA = 32'h0;
    tests++;
    if (okays != n) begin
      fails++; $display("FAIL b2b_push_okay: got %0d OKAY data phases, expected %0d", okays, n);
    end
  endtask

  task automatic test_reset();
    bus_idle(); bus.HWDATA = 32'h0;
    HRESETN = 1'b1;
    repeat (3) @(posedge HCLK);
    release_reset();
    tests++; if (bus.HREADY_OUT !== 1'b1) begin fails++; $display("FAIL reset_hready: got %b expected 1", bus.HREADY_OUT); end
    tests++; if (bus.HRESP !== 2'b00) begin fails++; $display("FAIL reset_hresp: got %b expected 00", bus.HRESP); end
    tests++; if (bus.HRDATA !== 32'h0) begin fails++; $display("FAIL reset_hrdata: got %h expected 0", bus.HRDATA); end
    tests++; if (bus.XFER_ERROR_ACCESS !== 1'b0) begin fails++; $display("FAIL reset_xfer: got %b expected 0", bus.XFER_ERROR_ACCESS); end
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1 || r_err) begin fails++; $display("FAIL reset_status: got %h err %b expected 00000001 err 0", r_data, r_err); end
    ahb_xfer(1'b0, A_CTRL, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h expected 0", r_data); end
    ahb_xfer(1'b0, A_SCRATCH, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0) begin fails++; $display("FAIL reset_scratch: got %h expected 0", r_data); end
  endtask

  task automatic test_scratch();
    ahb_xfer(1'b1, A_SCRATCH, W, 32'hDEAD_BEEF, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_err || r_waits != 0) begin fails++; $display("FAIL scratch_write: err %b waits %0d expected err 0 waits 0", r_err, r_waits); end
    ahb_xfer(1'b0, A_SCRATCH, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_waits != 1) begin fails++; $display("FAIL scratch_read_waits: got %0d expected 1", r_waits); end
    tests++; if (r_data !== 32'hDEAD_BEEF || r_err) begin fails++; $display("FAIL scratch_read: got %h err %b expected deadbeef err 0", r_data, r_err); end
  endtask

  task automatic test_fifo_fill();
    int bad = 0;
    ahb_xfer(1'b1, A_CTRL, W, 32'h1, r_data, r_err, r_waits, r_pulses, r_pfirst);
    push_b2b(8, 32'h1);
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0000_0802) begin fails++; $display("FAIL full_status: got %h expected 00000802", r_data); end
    ahb_xfer(1'b1, A_DATA, W, 32'h9, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (!r_err || r_waits != 1) begin fails++; $display("FAIL push_full_err: err %b waits %0d expected err 1 waits 1", r_err, r_waits); end
    tests++; if (r_pfirst !== 1'b1 || r_pulses != 1) begin fails++; $display("FAIL push_full_pulse: first %b count %0d expected 1 1", r_pfirst, r_pulses); end
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0000_0802) begin fails++; $display("FAIL status_after_err: got %h expected 00000802", r_data); end
    for (int i = 1; i <= 8; i++) begin
      ahb_xfer(1'b0, A_DATA, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
      tests++;
      if (r_data !== 32'(i) || r_err) begin fails++; bad++; $display("FAIL pop_%0d: got %h err %b expected %h", i, r_data, r_err, 32'(i)); end
    end
    ahb_xfer(1'b0, A_DATA, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (!r_err || r_data !== 32'h0) begin fails++; $display("FAIL pop_empty_err: err %b data %h expected err 1 data 0", r_err, r_data); end
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL drained_status: got %h expected 00000001", r_data); end
  endtask

  task automatic test_errors();
    ahb_xfer(1'b1, A_STATUS, W, 32'h55, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (!r_err) begin fails++; $display("FAIL err_status_write: err %b expected 1", r_err); end
    ahb_xfer(1'b1, A_SCRATCH, 3'b000, 32'h1111, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (!r_err) begin fails++; $display("FAIL err_hsize: err %b expected 1", r_err); end
    ahb_xfer(1'b1, BASE + 32'h10, W, 32'h2222, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (!r_err) begin fails++; $display("FAIL err_window: err %b expected 1", r_err); end
    ahb_xfer(1'b1, BASE + 32'h2, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (!r_err) begin fails++; $display("FAIL err_unaligned: err %b expected 1", r_err); end
    ahb_xfer(1'b1, A_CTRL, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    ahb_xfer(1'b1, A_DATA, W, 32'h77, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (!r_err) begin fails++; $display("FAIL err_push_disabled: err %b expected 1", r_err); end
    ahb_xfer(1'b1, A_CTRL, W, 32'h1, r_data, r_err, r_waits, r_pulses, r_pfirst);
    ahb_xfer(1'b0, A_SCRATCH, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL err_scratch_kept: got %h expected deadbeef", r_data); end
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL err_status_kept: got %h expected 00000001", r_data); end
    ahb_xfer(1'b0, A_CTRL, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL err_ctrl_kept: got %h expected 00000001", r_data); end
  endtask

  task automatic test_back_to_back();
    push_b2b(7, 32'h100);
    bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = A_DATA; bus.HSIZE = W;
    @(posedge HCLK); #1;
    tests++; if (bus.HRESP !== 2'b00 || bus.HREADY_OUT !== 1'b1) begin fails++; $display("FAIL inflight_first: resp %b ready %b expected 00 1", bus.HRESP, bus.HREADY_OUT); end
    bus.HWDATA = 32'hA7;
    @(posedge HCLK); #1;
    tests++; if (bus.HRESP !== 2'b01 || bus.HREADY_OUT !== 1'b0 || bus.XFER_ERROR_ACCESS !== 1'b1) begin
      fails++; $display("FAIL inflight_err1: resp %b ready %b xfer %b expected 01 0 1", bus.HRESP, bus.HREADY_OUT, bus.XFER_ERROR_ACCESS); end
    bus_idle(); bus.HWDATA = 32'h0;
    @(posedge HCLK); #1;
    tests++; if (bus.HRESP !== 2'b01 || bus.HREADY_OUT !== 1'b1 || bus.XFER_ERROR_ACCESS !== 1'b0) begin
      fails++; $display("FAIL inflight_err2: resp %b ready %b xfer %b expected 01 1 0", bus.HRESP, bus.HREADY_OUT, bus.XFER_ERROR_ACCESS); end
    @(posedge HCLK); #1;
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0000_0802) begin fails++; $display("FAIL inflight_status: got %h expected 00000802", r_data); end
    ahb_xfer(1'b0, A_DATA, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h100) begin fails++; $display("FAIL inflight_head: got %h expected 00000100", r_data); end
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0000_0700) begin fails++; $display("FAIL seven_status: got %h expected 00000700", r_data); end
  endtask

  task automatic test_flush();
    ahb_xfer(1'b1, A_CTRL, W, 32'h3, r_data, r_err, r_waits, r_pulses, r_pfirst);
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL flush7_status: got %h expected 00000001", r_data); end
    push_b2b(3, 32'h11);
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0000_0300) begin fails++; $display("FAIL three_status: got %h expected 00000300", r_data); end
    ahb_xfer(1'b1, A_CTRL, W, 32'h3, r_data, r_err, r_waits, r_pulses, r_pfirst);
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL flush3_status: got %h expected 00000001", r_data); end
    ahb_xfer(1'b0, A_CTRL, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL flush_ctrl: got %h expected 00000001", r_data); end
  endtask

  task automatic test_forwarding();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] addr;
      logic [31:0] val;
      addr = (k == 0) ? A_SCRATCH : A_DATA;
      val  = (k == 0) ? 32'h1234_5678 : 32'hCAFE_F00D;
      bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr; bus.HSIZE = W;
      @(posedge HCLK); #1;
      bus.HWDATA = val; bus.HWRITE = 1'b0;
      @(posedge HCLK); #1;
      bus_idle(); bus.HWDATA = 32'h0;
      cyc = 0;
      while (bus.HREADY_OUT !== 1'b1 && cyc < 10) begin @(posedge HCLK); #1; cyc++; end
      tests++;
      if (bus.HRDATA !== val || bus.HRESP !== 2'b00 || cyc != 1) begin
        fails++; $display("FAIL forward_%0d: got %h resp %b waits %0d expected %h 00 1", k, bus.HRDATA, bus.HRESP, cyc, val);
      end
      @(posedge HCLK); #1;
    end
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL forward_status: got %h expected 00000001", r_data); end
  endtask

  task automatic test_reset_mid();
    // reset during a read wait state
    bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = A_SCRATCH; bus.HSIZE = W;
    @(posedge HCLK); #1;
    bus_idle();
    tests++; if (bus.HREADY_OUT !== 1'b0) begin fails++; $display("FAIL mid_wait_entered: ready %b expected 0", bus.HREADY_OUT); end
    HRESETN = 1'b1; #1;
    tests++; if (bus.HREADY_OUT !== 1'b1 || bus.HRESP !== 2'b00 || bus.HRDATA !== 32'h0) begin
      fails++; $display("FAIL mid_wait_reset: ready %b resp %b data %h expected 1 00 0", bus.HREADY_OUT, bus.HRESP, bus.HRDATA); end
    release_reset();
    ahb_xfer(1'b0, A_SCRATCH, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0) begin fails++; $display("FAIL mid_wait_scratch: got %h expected 0", r_data); end
    ahb_xfer(1'b0, A_CTRL, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h0) begin fails++; $display("FAIL mid_wait_ctrl: got %h expected 0", r_data); end
    // reset during the first error cycle, with entries in the FIFO
    ahb_xfer(1'b1, A_CTRL, W, 32'h1, r_data, r_err, r_waits, r_pulses, r_pfirst);
    push_b2b(2, 32'h50);
    bus.HSELx = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = A_STATUS; bus.HSIZE = W;
    @(posedge HCLK); #1;
    bus_idle();
    tests++; if (bus.HRESP !== 2'b01 || bus.HREADY_OUT !== 1'b0 || bus.XFER_ERROR_ACCESS !== 1'b1) begin
      fails++; $display("FAIL mid_err_entered: resp %b ready %b xfer %b expected 01 0 1", bus.HRESP, bus.HREADY_OUT, bus.XFER_ERROR_ACCESS); end
    HRESETN = 1'b1; #1;
    tests++; if (bus.HREADY_OUT !== 1'b1 || bus.HRESP !== 2'b00 || bus.XFER_ERROR_ACCESS !== 1'b0) begin
      fails++; $display("FAIL mid_err_reset: ready %b resp %b xfer %b expected 1 00 0", bus.HREADY_OUT, bus.HRESP, bus.XFER_ERROR_ACCESS); end
    release_reset();
    ahb_xfer(1'b0, A_STATUS, W, 32'h0, r_data, r_err, r_waits, r_pulses, r_pfirst);
    tests++; if (r_data !== 32'h1) begin fails++; $display("FAIL mid_err_status: got %h expected 00000001", r_data); end
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_fifo_fill();
    test_errors();
    test_back_to_back();
    test_flush();
    test_forwarding();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
